add_sub_arbiter: RTL and testbench

ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

---
 rtl/add_sub_arbiter.sv | 141 ++++++++++++++
 tb/tb_add_sub_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter
//   Two requesters share a single 32-bit adder/subtractor. A round-robin
//   arbiter grants one requester per cycle. The granted operation is
//   registered into a one-entry response slot with valid/ready handshake.
//   The slot supports full throughput: a response can be consumed and a new
//   one loaded on the same edge.
//
// Ports
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_req{0,1}_valid, o_req{0,1}_ready  request handshake per requester
//   i_req{0,1}_sub                    0 = A+B, 1 = A-B
//   i_req{0,1}_a, i_req{0,1}_b          32-bit operands
//   o_rsp_valid, i_rsp_ready          response handshake
//   o_rsp_id                          requester that issued the response
//   o_rsp_result                      sum/difference modulo 2^32
//   o_rsp_cout, o_rsp_ovf, o_rsp_zero   carry-out, signed overflow, zero flag
//   o_busy                            mirrors o_rsp_valid

// Shared arithmetic unit. Subtraction is A + ~B + 1, so cout=1 means no borrow.
module add_sub_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] result,
  output logic        cout
);

  logic [31:0] b_eff;

  assign b_eff = sel ? ~b : b;
  assign {cout, result} = {1'b0, a} + {1'b0, b_eff} + {32'd0, sel};

endmodule

module add_sub_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic        i_req0_sub,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic        i_req1_sub,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_cout,
  output logic        o_rsp_ovf,
  output logic        o_rsp_zero,
  output logic        o_busy
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic        state;
  logic        rr;
  logic        slot_free;
  logic        any_valid;
  logic        grant_id;
  logic        accept;
  logic        op_sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic        alu_ovf;

  assign o_rsp_valid = (state == FULL);
  assign o_busy      = o_rsp_valid;

  // The slot can take a new operation if it is empty or being drained now.
  assign slot_free = !o_rsp_valid || i_rsp_ready;
  assign any_valid = i_req0_valid || i_req1_valid;

  // A lone requester always wins; on contention the round-robin pointer decides.
  always_comb begin
    grant_id = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_id = rr;
    end else if (i_req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is gated with the reset so nothing is accepted while reset is held.
  assign accept       = any_valid && slot_free && i_rst_n;
  assign o_req0_ready = accept && (grant_id == 1'b0);
  assign o_req1_ready = accept && (grant_id == 1'b1);

  assign op_sub = grant_id ? i_req1_sub : i_req0_sub;
  assign op_a   = grant_id ? i_req1_a   : i_req0_a;
  assign op_b   = grant_id ? i_req1_b   : i_req0_b;

  add_sub_32_bit u_add_sub (
    .a      (op_a),
    .b      (op_b),
    .sel    (op_sub),
    .result (alu_result),
    .cout   (alu_cout)
  );

  // Signed overflow: result sign differs from A when operands (B negated for
  // subtraction) have equal signs.
  assign alu_ovf = op_sub
                 ? ((op_a[31] != op_b[31]) && (alu_result[31] != op_a[31]))
                 : ((op_a[31] == op_b[31]) && (alu_result[31] != op_a[31]));

  // Response slot and round-robin pointer. A new accept always overwrites
  // the slot (it can only happen when the slot is free); otherwise a consumer
  // handshake empties it, and a stalled response simply holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= EMPTY;
      rr           <= 1'b0;
      o_rsp_id     <= 1'b0;
      o_rsp_result <= 32'd0;
      o_rsp_cout   <= 1'b0;
      o_rsp_ovf    <= 1'b0;
      o_rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        state        <= FULL;
        rr           <= ~grant_id;
        o_rsp_id     <= grant_id;
        o_rsp_result <= alu_result;
        o_rsp_cout   <= alu_cout;
        o_rsp_ovf    <= alu_ovf;
        o_rsp_zero   <= (alu_result == 32'd0);
      end else if (i_rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// tb_add_sub_arbiter
//   Self-checking bench for add_sub_arbiter. Directed vectors for the
//   documented corner cases, then randomized traffic, all compared against
//   a behavioural model that works with plain integer arithmetic.

module tb_add_sub_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic        req0_sub, req1_sub;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_ovf, rsp_zero;
  logic        busy;

  int check_count = 0;
  int error_count = 0;

  // Reference model state
  logic        m_valid;
  logic        m_id;
  logic [31:0] m_result;
  logic        m_cout, m_ovf, m_zero;
  logic        m_last_winner;
  logic        acc0, acc1;

  add_sub_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_sub   (req0_sub),
    .i_req0_a     (req0_a),
    .i_req0_b     (req0_b),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_sub   (req1_sub),
    .i_req1_a     (req1_a),
    .i_req1_b     (req1_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
    .o_rsp_cout   (rsp_cout),
    .o_rsp_ovf    (rsp_ovf),
    .o_rsp_zero   (rsp_zero),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Arithmetic reference: integer sums/differences, overflow from the true
  // signed result leaving the 32-bit range, carry from unsigned comparison.
  task automatic model_op(input logic sub, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic c, output logic o,
                          output logic z);
    longint sa, sb, st;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      st = sa - sb;
      r  = a - b;
      c  = (ua >= ub);
    end else begin
      st = sa + sb;
      r  = a + b;
      c  = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    end
    o = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    z = (r == 32'd0);
  endtask

  task automatic model_reset();
    m_valid       = 1'b0;
    m_id          = 1'b0;
    m_result      = 32'd0;
    m_cout        = 1'b0;
    m_ovf         = 1'b0;
    m_zero        = 1'b0;
    m_last_winner = 1'b1;
  endtask

  task automatic check_rsp(input string tag);
    check_output({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, m_valid});
    check_output({tag, ".busy"},  {31'd0, busy},      {31'd0, m_valid});
    if (m_valid) begin
      check_output({tag, ".id"},     {31'd0, rsp_id},   {31'd0, m_id});
      check_output({tag, ".result"}, rsp_result,        m_result);
      check_output({tag, ".cout"},   {31'd0, rsp_cout}, {31'd0, m_cout});
      check_output({tag, ".ovf"},    {31'd0, rsp_ovf},  {31'd0, m_ovf});
      check_output({tag, ".zero"},   {31'd0, rsp_zero}, {31'd0, m_zero});
    end
  endtask

  // Called shortly after a rising edge with inputs already driven. Checks the
  // readies mid-cycle, then advances one edge and checks the response.
  task automatic apply_stimulus(input string tag);
    logic exp0, exp1, slot, winner;
    logic [31:0] r;
    logic c, o, z;
    #4;
    slot = !m_valid || rsp_ready;
    exp0 = 1'b0;
    exp1 = 1'b0;
    if (slot) begin
      if (req0_valid && req1_valid) begin
        // alternate: whoever did not win last time wins now
        if (m_last_winner) exp0 = 1'b1; else exp1 = 1'b1;
      end else begin
        exp0 = req0_valid;
        exp1 = req1_valid;
      end
    end
    check_output({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, exp0});
    check_output({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, exp1});
    check_output({tag, ".onehot"}, {31'd0, req0_ready & req1_ready}, 32'd0);
    acc0 = exp0;
    acc1 = exp1;
    if (exp0 || exp1) begin
      winner = exp1;
      if (winner) model_op(req1_sub, req1_a, req1_b, r, c, o, z);
      else        model_op(req0_sub, req0_a, req0_b, r, c, o, z);
      m_valid       = 1'b1;
      m_id          = winner;
      m_result      = r;
      m_cout        = c;
      m_ovf         = o;
      m_zero        = z;
      m_last_winner = winner;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_rsp(tag);
  endtask

  task automatic set_req(input int n, input logic v, input logic sub,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_sub = sub; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_sub = sub; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_0001;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  logic [31:0] held_result;

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    acc0 = 1'b0;
    acc1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_rsp("reset");
    check_output("reset.result", rsp_result, 32'd0);
    check_output("reset.ready0", {31'd0, req0_ready}, 32'd0);
    rst_n = 1'b1;

    // Simple add on req0
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0003);
    apply_stimulus("add5p3");
    check_output("add5p3.const", rsp_result, 32'h0000_0008);
    check_output("add5p3.cout",  {31'd0, rsp_cout}, 32'd0);

    // Subtractions on req1
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b1, 32'd5, 32'd5);
    apply_stimulus("sub5m5");
    check_output("sub5m5.zero", {31'd0, rsp_zero}, 32'd1);
    check_output("sub5m5.cout", {31'd0, rsp_cout}, 32'd1);
    set_req(1, 1'b1, 1'b1, 32'h8000_0000, 32'd1);
    apply_stimulus("subovf");
    check_output("subovf.const", rsp_result, 32'h7FFF_FFFF);
    check_output("subovf.ovf",   {31'd0, rsp_ovf}, 32'd1);

    // Add overflow / wrap on req0
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
    apply_stimulus("addovf");
    check_output("addovf.const", rsp_result, 32'h8000_0000);
    check_output("addovf.ovf",   {31'd0, rsp_ovf}, 32'd1);
    set_req(0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    apply_stimulus("addwrap");
    check_output("addwrap.zero", {31'd0, rsp_zero}, 32'd1);
    check_output("addwrap.ovf",  {31'd0, rsp_ovf},  32'd0);

    // Contention: alternating grants at one op per cycle
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, 1'(i & 1), $urandom, $urandom);
      set_req(1, 1'b1, 1'(~i & 1), $urandom, $urandom);
      apply_stimulus("rr");
    end

    // Backpressure: response held for 3 cycles, then replaced on drain
    rsp_ready   = 1'b0;
    held_result = rsp_result;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus("stall");
      check_output("stall.hold", rsp_result, held_result);
    end
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'd10, 32'd20);
    apply_stimulus("drain");
    check_output("drain.const", rsp_result, 32'd30);

    // Randomized traffic; requesters hold operands until accepted
    for (int i = 0; i < 2000; i++) begin
      if (acc0 || !req0_valid)
        set_req(0, $urandom_range(0, 3) != 0, 1'($urandom), rand_operand(), rand_operand());
      if (acc1 || !req1_valid)
        set_req(1, $urandom_range(0, 3) != 0, 1'($urandom), rand_operand(), rand_operand());
      rsp_ready = $urandom_range(0, 3) != 0;
      apply_stimulus("rand");
    end

    // Reset mid-operation with rr pointing at req1
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(0, 1'b1, 1'b0, 32'd1, 32'd2);
    rsp_ready = 1'b1;
    apply_stimulus("prerst");
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'd7, 32'd8);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_rsp("midrst");
    check_output("midrst.result", rsp_result, 32'd0);
    check_output("midrst.id",     {31'd0, rsp_id}, 32'd0);
    check_output("midrst.ready0", {31'd0, req0_ready}, 32'd0);
    check_output("midrst.ready1", {31'd0, req1_ready}, 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    apply_stimulus("postrst");
    check_output("postrst.id", {31'd0, rsp_id}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
